// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two-port (CPU, host) arbiter in front of a single-ported data memory.
//   Each granted request spends exactly one cycle in ACCESS; reads return
//   their data one cycle after the grant. CPU has priority, but the host is
//   guaranteed a slot after STARVE_MAX consecutive CPU grants made while
//   the host was waiting.
//
// Ports
//   CLK, RST                      clock, asynchronous active-high reset
//   cpu_req/rw/addr/wd            CPU request (held stable until cpu_gnt)
//   cpu_gnt, cpu_rvalid, cpu_rd   CPU grant pulse, read-valid pulse, read data
//   host_*                        same set for the host port
//   mem_addr/rw/wd                memory address, write enable, write data
//   mem_rd                        memory combinational read data
//   err                           pulses with gnt for a misaligned request
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rd,
  input  logic        host_req,
  input  logic        host_rw,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wd,
  output logic        host_gnt,
  output logic        host_rvalid,
  output logic [31:0] host_rd,
  output logic [31:0] mem_addr,
  output logic        mem_rw,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic        err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

  state_t      r_state;
  logic        r_winner_host;
  logic        r_rw;
  logic [3:0]  r_starve_cnt;

  logic        w_host_wins;
  logic        w_sel_rw;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wd;
  logic        w_sel_aligned;

  // Host wins when it is the only requester, or when the CPU has already
  // taken STARVE_MAX grants in a row while the host was waiting.
  assign w_host_wins   = host_req & (~cpu_req | (r_starve_cnt == LP_STARVE_MAX));
  assign w_sel_rw      = w_host_wins ? host_rw   : cpu_rw;
  assign w_sel_addr    = w_host_wins ? host_addr : cpu_addr;
  assign w_sel_wd      = w_host_wins ? host_wd   : cpu_wd;
  assign w_sel_aligned = (w_sel_addr[1:0] == 2'b00);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= IDLE;
      r_winner_host <= 1'b0;
      r_rw          <= 1'b0;
      r_starve_cnt  <= 4'd0;
      cpu_gnt       <= 1'b0;
      cpu_rvalid    <= 1'b0;
      cpu_rd        <= 32'd0;
      host_gnt      <= 1'b0;
      host_rvalid   <= 1'b0;
      host_rd       <= 32'd0;
      mem_addr      <= 32'd0;
      mem_rw        <= 1'b0;
      mem_wd        <= 32'd0;
      err           <= 1'b0;
    end else begin
      cpu_rvalid  <= 1'b0;
      host_rvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cpu_req | host_req) begin
            r_state       <= ACCESS;
            r_winner_host <= w_host_wins;
            r_rw          <= w_sel_rw;
            mem_addr      <= w_sel_addr;
            mem_wd        <= w_sel_wd;
            mem_rw        <= w_sel_rw & w_sel_aligned;
            err           <= ~w_sel_aligned;
            cpu_gnt       <= ~w_host_wins;
            host_gnt      <= w_host_wins;
            // Count only CPU wins that made a waiting host lose.
            if (!host_req || w_host_wins)
              r_starve_cnt <= 4'd0;
            else if (r_starve_cnt != LP_STARVE_MAX)
              r_starve_cnt <= r_starve_cnt + 4'd1;
          end
        end
        ACCESS: begin
          r_state  <= IDLE;
          cpu_gnt  <= 1'b0;
          host_gnt <= 1'b0;
          err      <= 1'b0;
          mem_rw   <= 1'b0;
          mem_wd   <= 32'd0;
          if (!r_rw) begin
            // err still flags misalignment here; misaligned reads return 0.
            if (r_winner_host) begin
              host_rd     <= err ? 32'd0 : mem_rd;
              host_rvalid <= 1'b1;
            end else begin
              cpu_rd      <= err ? 32'd0 : mem_rd;
              cpu_rvalid  <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cpu_req, cpu_rw, host_req, host_rw;
  logic [31:0] cpu_addr, cpu_wd, host_addr, host_wd;
  logic        cpu_gnt, cpu_rvalid, host_gnt, host_rvalid;
  logic [31:0] cpu_rd, host_rd;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_rw, err;

  int n_checks = 0;
  int n_errs   = 0;

  logic [31:0] mem_model [0:63] = '{default: 32'd0};

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (mem_rw) mem_model[mem_addr[7:2]] <= mem_wd;
  assign mem_rd = mem_model[mem_addr[7:2]];

  mem_port_arbiter #(.STARVE_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rd(cpu_rd),
    .host_req(host_req), .host_rw(host_rw), .host_addr(host_addr), .host_wd(host_wd),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rd(host_rd),
    .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    bit          port;     // 0 cpu, 1 host
    bit          rw;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          exp_err;
    logic [31:0] exp_rd;
    logic [31:0] chk_addr;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs [9];

  task automatic do_access(input vec_t v);
    logic [31:0] loser_rd;
    bit exp_rv;
    @(posedge CLK); #1;
    if (v.port) begin
      host_req = 1'b1; host_rw = v.rw; host_addr = v.addr; host_wd = v.wd;
    end else begin
      cpu_req = 1'b1; cpu_rw = v.rw; cpu_addr = v.addr; cpu_wd = v.wd;
    end
    loser_rd = v.port ? cpu_rd : host_rd;
    @(negedge CLK);
    chk({v.name, " no gnt before arb"}, {31'd0, cpu_gnt | host_gnt}, 32'd0);
    @(negedge CLK);
    chk({v.name, " gnt"}, {30'd0, cpu_gnt, host_gnt}, v.port ? 32'd1 : 32'd2);
    chk({v.name, " err"}, {31'd0, err}, {31'd0, v.exp_err});
    chk({v.name, " mem_rw"}, {31'd0, mem_rw}, {31'd0, v.rw & ~v.exp_err});
    chk({v.name, " mem_addr"}, mem_addr, v.addr);
    chk({v.name, " mem_wd"}, mem_wd, v.wd);
    @(posedge CLK); #1;
    cpu_req = 1'b0; host_req = 1'b0;
    @(negedge CLK);
    exp_rv = ~v.rw;
    chk({v.name, " gnt dropped"}, {30'd0, cpu_gnt, host_gnt}, 32'd0);
    chk({v.name, " rvalid"}, {30'd0, cpu_rvalid, host_rvalid},
        v.port ? {31'd0, exp_rv} : {30'd0, exp_rv, 1'b0});
    chk({v.name, " mem_rw idle"}, {31'd0, mem_rw}, 32'd0);
    if (!v.rw) chk({v.name, " rd"}, v.port ? host_rd : cpu_rd, v.exp_rd);
    chk({v.name, " loser rd held"}, v.port ? cpu_rd : host_rd, loser_rd);
    chk({v.name, " mem word"}, mem_model[v.chk_addr[7:2]], v.exp_mem);
  endtask

  initial begin
    int ngr;
    bit order [10];
    bit exp_order [10];
    bit prev_g;

    RST = 1'b1;
    cpu_req = 0; cpu_rw = 0; cpu_addr = 0; cpu_wd = 0;
    host_req = 0; host_rw = 0; host_addr = 0; host_wd = 0;

    vecs[0] = '{"cpu_wr_10",  1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0,        32'h10, 32'hDEADBEEF};
    vecs[1] = '{"cpu_rd_10",  1'b0, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 32'h10, 32'hDEADBEEF};
    vecs[2] = '{"host_rd_22", 1'b1, 1'b0, 32'h22, 32'h0,        1'b1, 32'h0,        32'h20, 32'h0};
    vecs[3] = '{"host_wr_08", 1'b1, 1'b1, 32'h08, 32'h55,       1'b0, 32'h0,        32'h08, 32'h55};
    vecs[4] = '{"cpu_rd_08",  1'b0, 1'b0, 32'h08, 32'h0,        1'b0, 32'h55,       32'h08, 32'h55};
    vecs[5] = '{"cpu_wr_13",  1'b0, 1'b1, 32'h13, 32'h0000FFFF, 1'b1, 32'h0,        32'h10, 32'hDEADBEEF};
    vecs[6] = '{"host_wr_30", 1'b1, 1'b1, 32'h30, 32'hA5A5A5A5, 1'b0, 32'h0,        32'h30, 32'hA5A5A5A5};
    vecs[7] = '{"host_rd_30", 1'b1, 1'b0, 32'h30, 32'h0,        1'b0, 32'hA5A5A5A5, 32'h30, 32'hA5A5A5A5};
    vecs[8] = '{"cpu_rd_31",  1'b0, 1'b0, 32'h31, 32'h0,        1'b1, 32'h0,        32'h30, 32'hA5A5A5A5};

    #12;
    chk("reset gnt/rvalid/err", {27'd0, cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, err}, 32'd0);
    chk("reset mem_rw", {31'd0, mem_rw}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_wd", mem_wd, 32'd0);
    chk("reset cpu_rd", cpu_rd, 32'd0);
    chk("reset host_rd", host_rd, 32'd0);
    @(negedge CLK); RST = 1'b0;

    for (int i = 0; i < 9; i++) do_access(vecs[i]);

    // Both ports held: expect CPU x4 then HOST, repeating, never back-to-back.
    exp_order = '{0,0,0,0,1,0,0,0,0,1};
    @(posedge CLK); #1;
    cpu_req = 1; cpu_rw = 0; cpu_addr = 32'h10;
    host_req = 1; host_rw = 0; host_addr = 32'h30;
    ngr = 0; prev_g = 0;
    for (int c = 0; c < 40 && ngr < 10; c++) begin
      @(negedge CLK);
      if (cpu_gnt && host_gnt) chk("starve both gnt", 32'd1, 32'd0);
      if (cpu_gnt || host_gnt) begin
        if (prev_g) chk("starve gnt spacing", 32'd1, 32'd0);
        order[ngr] = host_gnt;
        ngr++;
      end
      prev_g = cpu_gnt | host_gnt;
    end
    @(posedge CLK); #1;
    cpu_req = 0; host_req = 0;
    chk("starve grant count", ngr, 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("starve order %0d (1=host)", i), {31'd0, order[i]}, {31'd0, exp_order[i]});
    @(negedge CLK);
    chk("starve cpu_rd", cpu_rd, 32'hDEADBEEF);
    chk("starve host_rd", host_rd, 32'hA5A5A5A5);

    // Reset in the ACCESS cycle of a CPU write aborts it.
    @(posedge CLK); #1;
    cpu_req = 1; cpu_rw = 1; cpu_addr = 32'h20; cpu_wd = 32'h1;
    @(negedge CLK);
    @(negedge CLK);
    chk("abort pre mem_rw", {31'd0, mem_rw}, 32'd1);
    #1 RST = 1'b1;
    #1;
    chk("abort mem_rw drop", {31'd0, mem_rw}, 32'd0);
    chk("abort gnt drop", {31'd0, cpu_gnt}, 32'd0);
    chk("abort cpu_rd clr", cpu_rd, 32'd0);
    chk("abort host_rd clr", host_rd, 32'd0);
    chk("abort mem_addr clr", mem_addr, 32'd0);
    cpu_req = 0;
    @(posedge CLK);
    @(negedge CLK); RST = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      chk($sformatf("abort quiet %0d", c), {30'd0, cpu_gnt, cpu_rvalid}, 32'd0);
    end
    chk("abort word 20", mem_model[8], 32'd0);

    // Idle bus
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      chk($sformatf("idle %0d", c), {26'd0, mem_rw, cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, err}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
